// File: rtl/dmux_pkg.sv
// Shared types and defaults for the toggle-handshake CDC transmitter.
package dmux_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        GAP      = 2'd2
    } state_e;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // Width of the shared gap/timeout counter; never narrower than one bit.
    function automatic int cnt_width(input int gap_cyc, input int timeout_cyc);
        int max_v;
        max_v = (gap_cyc > timeout_cyc) ? gap_cyc : timeout_cyc;
        return (max_v > 0) ? $clog2(max_v + 1) : 1;
    endfunction

endpackage

// File: rtl/dmux_handshake_tx_sync_bit.sv
// Single-bit multi-flop synchroniser used to bring the destination's ack toggle into clk_a.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; the first flop may go metastable, the last one feeds logic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dmux_handshake_tx.sv
// Source side of a toggle-handshake multi-bit CDC: holds one word and flips req_toggle per word,
// refusing new words until the destination echoes the toggle back on ack_toggle.
module dmux_handshake_tx
    import dmux_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int GAP_CYC     = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_a,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    output logic [DATA_W-1:0] data_hold,
    output logic              req_toggle,
    input  logic              ack_toggle,
    output logic              busy,
    output logic              timeout_err
);

    localparam int               CNT_W    = cnt_width(GAP_CYC, TIMEOUT_CYC);
    localparam bit               TO_EN    = (TIMEOUT_CYC != 0);
    localparam bit               GAP_EN   = (GAP_CYC != 0);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_EN ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              req_q, req_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              ack_sync_s;
    logic              accept_s;
    logic              ack_match_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_i  (clk_a),
        .rst_ni (rst_n),
        .d_i    (ack_toggle),
        .q_o    (ack_sync_s)
    );

    // ready_q is high exactly while idle, so it doubles as the accept qualifier.
    assign accept_s    = data_in_valid && ready_q;
    assign ack_match_s = (ack_sync_s == req_q);

    // State register.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack changes outside WAIT_ACK are deliberately not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = WAIT_ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_ACK: begin
                if (ack_match_s && GAP_EN) begin
                    state_d = GAP;
                end else if (ack_match_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: word capture, toggle, shared counter and timeout pulse.
    always_comb begin
        hold_d = hold_q;
        req_d  = req_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;

        if (accept_s) begin
            hold_d = data_in;
            req_d  = ~req_q;
        end else begin
            hold_d = hold_q;
            req_d  = req_q;
        end

        case (state_q)
            IDLE: cnt_d = '0;
            WAIT_ACK: begin
                if (ack_match_s) begin
                    cnt_d = '0;
                end else if (TO_EN && (cnt_q != TO_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: cnt_d = '0;
        endcase

        // The counter saturates at TO_MAX, so this edge-detect fires only once per wait.
        if ((state_q == WAIT_ACK) && !ack_match_s && TO_EN &&
            (cnt_q != TO_MAX) && (cnt_d == TO_MAX)) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            req_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hold_q  <= hold_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_in_ready = ready_q;
    assign data_hold     = hold_q;
    assign req_toggle    = req_q;
    assign busy          = busy_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_dmux_handshake_tx.sv
// Bench for dmux_handshake_tx: two instances (no gap / short timeout, and 3-cycle gap) checked
// every cycle against an edge-timestamp model, plus literal expectations for the directed tests.
module tb_dmux_handshake_tx;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int HIST = 4096;

    logic          clk_a = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din      [2];
    logic          vld      [2];
    logic          ack_drv  [2];
    logic          loop_ack [2];
    logic          loop_en  [2];
    logic          ack_t    [2];
    logic          rdy      [2];
    logic [DW-1:0] hold     [2];
    logic          req      [2];
    logic          busy     [2];
    logic          terr     [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_a = ~clk_a;

    assign ack_t[0] = loop_en[0] ? loop_ack[0] : ack_drv[0];
    assign ack_t[1] = loop_en[1] ? loop_ack[1] : ack_drv[1];

    // Loopback destination: echoes req back half a cycle later.
    always @(negedge clk_a) begin
        loop_ack[0] <= req[0];
        loop_ack[1] <= req[1];
    end

    dmux_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(SYNC), .GAP_CYC(0), .TIMEOUT_CYC(10)) dut0 (
        .clk_a(clk_a), .rst_n(rst_n), .data_in(din[0]), .data_in_valid(vld[0]),
        .data_in_ready(rdy[0]), .data_hold(hold[0]), .req_toggle(req[0]),
        .ack_toggle(ack_t[0]), .busy(busy[0]), .timeout_err(terr[0]));

    dmux_handshake_tx #(.DATA_W(DW), .SYNC_STAGES(SYNC), .GAP_CYC(3), .TIMEOUT_CYC(255)) dut1 (
        .clk_a(clk_a), .rst_n(rst_n), .data_in(din[1]), .data_in_valid(vld[1]),
        .data_in_ready(rdy[1]), .data_hold(hold[1]), .req_toggle(req[1]),
        .ack_toggle(ack_t[1]), .busy(busy[1]), .timeout_err(terr[1]));

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic int to_of(input int i);
        return (i == 0) ? 10 : 255;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: rising edges are numbered, ack is remembered per edge ----------------
    int            ecnt      = 0;
    int            run_start = 1;
    bit            ack_hist  [2][HIST];
    bit            m_wait    [2] = '{1'b0, 1'b0};
    bit            m_req     [2] = '{1'b0, 1'b0};
    bit            m_err     [2] = '{1'b0, 1'b0};
    bit            m_ready   [2] = '{1'b1, 1'b1};
    logic [DW-1:0] m_hold    [2] = '{8'h00, 8'h00};
    int            m_acc     [2] = '{0, 0};
    int            m_rdy_at  [2] = '{0, 0};

    // ack value the source domain has seen at edge idx (synchroniser flops are 0 before that).
    function automatic bit ack_seen(input int i, input int idx);
        if (idx < run_start) return 1'b0;
        return ack_hist[i][idx % HIST];
    endfunction

    // A word accepted at edge A is released at the first later edge e whose ack sample from
    // SYNC edges earlier equals the new req; ready follows GAP edges after that.
    always @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            run_start = ecnt + 1;
            for (int i = 0; i < 2; i++) begin
                m_wait[i]   = 1'b0;
                m_req[i]    = 1'b0;
                m_err[i]    = 1'b0;
                m_ready[i]  = 1'b1;
                m_hold[i]   = '0;
                m_rdy_at[i] = 0;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                ack_hist[i][ecnt % HIST] = ack_t[i];
                m_err[i] = 1'b0;
                if (m_ready[i]) begin
                    if (vld[i]) begin
                        m_hold[i] = din[i];
                        m_req[i]  = ~m_req[i];
                        m_acc[i]  = ecnt;
                        m_wait[i] = 1'b1;
                    end
                end else if (m_wait[i]) begin
                    if (ack_seen(i, ecnt - SYNC) == m_req[i]) begin
                        m_wait[i]   = 1'b0;
                        m_rdy_at[i] = ecnt + gap_of(i);
                    end else if (ecnt == m_acc[i] + to_of(i)) begin
                        m_err[i] = 1'b1;
                    end
                end
                m_ready[i] = !m_wait[i] && (ecnt >= m_rdy_at[i]);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_a) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cmp_ready%0d", i), rdy[i],  m_ready[i]);
            chk($sformatf("cmp_busy%0d", i),  busy[i], !m_ready[i]);
            chk($sformatf("cmp_hold%0d", i),  hold[i], m_hold[i]);
            chk($sformatf("cmp_req%0d", i),   req[i],  m_req[i]);
            chk($sformatf("cmp_terr%0d", i),  terr[i], m_err[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic accept(input int i, input logic [DW-1:0] d);
        bit r;
        bit done;
        done   = 1'b0;
        din[i] = d;
        vld[i] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            r = rdy[i];
            tick();
            if (r) begin
                done = 1'b1;
                break;
            end
        end
        vld[i] = 1'b0;
        chk("accept_taken", done, 1);
    endtask

    task automatic wait_ready(input int i, input int max_c);
        for (int n = 0; n < max_c; n++) begin
            if (rdy[i]) break;
            tick();
        end
        chk("wait_ready", rdy[i], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            tog;
        int            pulses;
        logic          prev;
        bit            r;
        logic [DW-1:0] t3_words [3];
        t3_words = '{8'h01, 8'h02, 8'h03};

        for (int i = 0; i < 2; i++) begin
            din[i] = '0; vld[i] = 1'b0; ack_drv[i] = 1'b0; loop_en[i] = 1'b0;
        end

        // T1: reset values
        rst_n = 1'b0;
        repeat (2) tick();
        chk("t1_ready", rdy[0], 1);
        chk("t1_req",   req[0], 0);
        chk("t1_hold",  hold[0], 0);
        chk("t1_busy",  busy[0], 0);
        chk("t1_terr",  terr[0], 0);
        rst_n = 1'b1;
        tick();

        // T2: single transfer, ack echoed 4 cycles after the accept
        accept(0, 8'hA5);
        chk("t2_hold",      hold[0], 8'hA5);
        chk("t2_req",       req[0], 1);
        chk("t2_ready_low", rdy[0], 0);
        chk("t2_busy",      busy[0], 1);
        repeat (4) tick();
        ack_drv[0] = 1'b1;
        tick(); chk("t2_ready_k1", rdy[0], 0);
        tick(); chk("t2_ready_k2", rdy[0], 0);
        tick(); chk("t2_ready_k3", rdy[0], 1);

        // T3: back-to-back words with loopback ack
        loop_en[0] = 1'b1;
        tog  = 0;
        prev = req[0];
        for (int w = 0; w < 3; w++) begin
            din[0] = t3_words[w];
            vld[0] = 1'b1;
            for (int n = 0; n < 20; n++) begin
                r = rdy[0];
                tick();
                if (req[0] !== prev) begin
                    tog++;
                    prev = req[0];
                end
                if (r) break;
            end
            chk("t3_hold", hold[0], t3_words[w]);
        end
        vld[0] = 1'b0;
        repeat (6) begin
            tick();
            if (req[0] !== prev) begin
                tog++;
                prev = req[0];
            end
        end
        chk("t3_toggles", tog, 3);
        chk("t3_ready",   rdy[0], 1);
        ack_drv[0] = 1'b0;
        loop_en[0] = 1'b0;

        // T4: data/valid changes while waiting for ack are ignored
        accept(0, 8'h3C);
        din[0] = 8'hFF;
        vld[0] = 1'b1;
        repeat (3) tick();
        chk("t4_hold", hold[0], 8'h3C);
        chk("t4_req",  req[0], 1);
        vld[0] = 1'b0;
        ack_drv[0] = 1'b1;
        wait_ready(0, 10);
        chk("t4_hold_after", hold[0], 8'h3C);

        // T5: ack withheld -> single timeout pulse 10 cycles after entry, then a late ack
        accept(0, 8'h5A);
        pulses = 0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 10) chk("t5_err_at10", terr[0], 1);
            if (terr[0]) pulses++;
        end
        chk("t5_pulses", pulses, 1);
        chk("t5_busy",   busy[0], 1);
        ack_drv[0] = 1'b0;
        wait_ready(0, 10);
        chk("t5_hold", hold[0], 8'h5A);

        // T6: 3-cycle gap on dut1, then reset in the middle of a wait
        accept(1, 8'h77);
        tick();
        ack_drv[1] = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("t6_ready_gap", rdy[1], (j == 6) ? 32'd1 : 32'd0);
        end
        accept(1, 8'h99);
        tick();
        chk("t6_busy_pre_rst", busy[1], 1);
        @(posedge clk_a);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", rdy[1], 1);
        chk("t6_rst_req",   req[1], 0);
        chk("t6_rst_hold",  hold[1], 0);
        chk("t6_rst_busy",  busy[1], 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_spurious_idle", rdy[1], 1);
        accept(1, 8'h42);
        wait_ready(1, 10);
        chk("t6_after_hold", hold[1], 8'h42);
        chk("t6_after_req",  req[1], 1);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
